load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter: TIMEOUT_CYCLES, default 255, maximum number of cycles spent in REQ plus WAIT before a bus error.
REQ-003 Port: clk_i  in  1  rising-edge clock.
REQ-004 Port: rst_ni  in  1  asynchronous active-low reset.
REQ-005 Ports from EX/MEM:
- valid_i  in  1  instruction present.
- mem_read_i  in  1  load.
- mem_write_i  in  1  store.
- funct3_i  in  3  access size and sign.
- addr_i  in  32  byte address.
- wdata_i  in  32  store data.
REQ-006 Ports to pipeline:
- stall_o  out  1  hold upstream stages.
- result_valid_o  out  1  access complete.
- rdata_o  out  32  extended load data, feeds the writeback select d1 input.
- misaligned_o  out  1  misaligned-access pulse.
- bus_err_o  out  1  timeout pulse.
REQ-007 Ports to data memory:
- dmem_req_o  out  1.
- dmem_we_o  out  1.
- dmem_be_o  out  4.
- dmem_addr_o  out  32  word-aligned, bits [1:0]=0.
- dmem_wdata_o  out  32.
- dmem_gnt_i  in  1.
- dmem_rvalid_i  in  1.
- dmem_rdata_i  in  32.

Function
REQ-008 FSM states SHALL be IDLE, REQ, WAIT and DONE.
REQ-009 In IDLE, valid_i and (mem_read_i or mem_write_i) SHALL register address, data, size and direction, and move to REQ.
- The request is a load if mem_read_i is high, including when mem_write_i is also high.
- stall_o SHALL be 1 combinationally in that cycle.
REQ-010 If valid_i is high with neither mem_read_i nor mem_write_i, the FSM SHALL remain in IDLE with stall_o=0 and rdata_o held.
REQ-011 In REQ, dmem_req_o SHALL be 1 and all dmem_* outputs SHALL be held stable until dmem_gnt_i=1, then the FSM SHALL move to WAIT.
REQ-012 In WAIT, dmem_req_o SHALL be 0. On dmem_rvalid_i=1 the FSM SHALL move to DONE; loads capture the extended data into rdata_o, stores ignore dmem_rdata_i.
REQ-013 DONE SHALL last exactly one cycle with result_valid_o=1 and stall_o=0, then return to IDLE unconditionally; valid_i seen in DONE SHALL NOT start a new access.
REQ-014 stall_o SHALL be 1 in REQ and WAIT.
- Minimum latency from acceptance to result_valid_o is 3 cycles (gnt and rvalid each arrive on the first cycle).
REQ-015 Loads SHALL select lanes by the registered addr[1:0]:
- LB (000) and LBU (100): byte, sign-extended or zero-extended.
- LH (001) and LHU (101): halfword, sign-extended or zero-extended.
- LW (010): full word.
REQ-016 Stores SHALL drive byte enables and lane data:
- SB: dmem_be_o=4'b0001<<addr[1:0], byte replicated on all four lanes.
- SH: dmem_be_o=4'b0011<<{addr[1],1'b0}, halfword replicated on both halves.
- SW: dmem_be_o=4'b1111.
REQ-017 Reserved funct3 (011, 110, 111) SHALL issue no bus access; the FSM goes IDLE->DONE with rdata_o=0.
REQ-018 A cycle counter SHALL run in REQ and WAIT.
- On reaching TIMEOUT_CYCLES the FSM SHALL go to DONE with rdata_o=0 and bus_err_o=1 for that DONE cycle.
- dmem_req_o SHALL drop immediately on timeout.
REQ-019 Loads SHALL NOT write rdata_o except on DONE entry; stores leave rdata_o unchanged.

Reset
REQ-020 While rst_ni=0, the FSM SHALL be in IDLE, the counter 0, and all outputs 0, including dmem_req_o, stall_o, rdata_o and dmem_be_o.
REQ-021 Reset asserted mid-access SHALL abandon the transaction immediately; a late dmem_rvalid_i after reset release in IDLE SHALL be ignored.

Configuration
REQ-022 Macro LSU_MISALIGN_TRAP_EN:
- Defined: an LH/LHU/SH with addr[0]=1, or an LW/SW with addr[1:0]!=0, SHALL issue no bus access and go IDLE->DONE with misaligned_o=1 for the DONE cycle and rdata_o=0.
- Undefined: misaligned_o SHALL be tied 0; halfword accesses ignore addr[0] and word accesses ignore addr[1:0].

Verification
REQ-023 LW, addr=0x100, gnt and rvalid immediate, rdata=0xDEADBEEF -> dmem_addr_o=0x100, be=1111, result_valid_o 3 cycles after accept, rdata_o=0xDEADBEEF.
REQ-024 LB, addr=0x103, dmem_rdata=0x80FF_0000 -> rdata_o=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-025 SH, addr=0x202, wdata=0x1234ABCD, gnt delayed 4 cycles -> REQ outputs stable 4 cycles, be=1100, dmem_wdata_o=0xABCDABCD, stall_o high throughout.
REQ-026 LW, addr=0x100, rvalid never arrives, TIMEOUT_CYCLES=8 -> bus_err_o=1 and result_valid_o=1 after 8 cycles, rdata_o=0.
REQ-027 LW, addr=0x102 -> with macro: no dmem_req_o, misaligned_o=1 one cycle after accept; without macro: dmem_addr_o=0x100 issued.
REQ-028 rst_ni low during WAIT -> dmem_req_o and stall_o 0 immediately; a later rvalid produces no result_valid_o.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding data-memory access with lane steering, sign extension
// and a REQ+WAIT timeout. Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        result_valid_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o,
  output logic        bus_err_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e          state_q;
  logic [1:0]      addr_lo_q;
  logic [2:0]      f3_q;
  logic            we_q;
  logic [CntW-1:0] cnt_q;

  logic        accept, reserved, misalign, timeout;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  always_comb begin
    accept   = (state_q == StIdle) && valid_i && (mem_read_i || mem_write_i);
    reserved = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
               ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    timeout  = (cnt_q == CntLast);
    // Gated by reset so every output reads 0 while reset is held.
    stall_o  = rst_ni && (accept || (state_q == StReq) || (state_q == StWait));

    case (funct3_i[1:0])
      2'b00: begin
        be_new    = 4'b0001 << addr_i[1:0];
        wdata_new = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << {addr_i[1], 1'b0};
        wdata_new = {2{wdata_i[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = wdata_i;
      end
    endcase

    byte_sel = dmem_rdata_i[{addr_lo_q, 3'b000} +: 8];
    half_sel = addr_lo_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (f3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'h0, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'h0, half_sel};
      default: load_ext = dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      addr_lo_q      <= 2'b00;
      f3_q           <= 3'b000;
      we_q           <= 1'b0;
      cnt_q          <= '0;
      result_valid_o <= 1'b0;
      rdata_o        <= 32'h0;
      bus_err_o      <= 1'b0;
      dmem_req_o     <= 1'b0;
      dmem_we_o      <= 1'b0;
      dmem_be_o      <= 4'b0000;
      dmem_addr_o    <= 32'h0;
      dmem_wdata_o   <= 32'h0;
    end else begin
      result_valid_o <= 1'b0;
      bus_err_o      <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            addr_lo_q <= addr_i[1:0];
            f3_q      <= funct3_i;
            we_q      <= mem_write_i && !mem_read_i;
            cnt_q     <= '0;
            if (reserved || misalign) begin
              state_q        <= StDone;
              result_valid_o <= 1'b1;
              rdata_o        <= 32'h0;
            end else begin
              state_q      <= StReq;
              dmem_req_o   <= 1'b1;
              dmem_we_o    <= mem_write_i && !mem_read_i;
              dmem_be_o    <= be_new;
              dmem_addr_o  <= {addr_i[31:2], 2'b00};
              dmem_wdata_o <= wdata_new;
            end
          end
        end
        StReq: begin
          cnt_q <= cnt_q + 1'b1;
          // A timeout wins over a same-cycle grant: the access is abandoned.
          if (timeout) begin
            state_q        <= StDone;
            dmem_req_o     <= 1'b0;
            result_valid_o <= 1'b1;
            bus_err_o      <= 1'b1;
            rdata_o        <= 32'h0;
          end else if (dmem_gnt_i) begin
            state_q    <= StWait;
            dmem_req_o <= 1'b0;
          end
        end
        StWait: begin
          cnt_q <= cnt_q + 1'b1;
          if (dmem_rvalid_i) begin
            state_q        <= StDone;
            result_valid_o <= 1'b1;
            if (!we_q) rdata_o <= load_ext;
          end else if (timeout) begin
            state_q        <= StDone;
            result_valid_o <= 1'b1;
            bus_err_o      <= 1'b1;
            rdata_o        <= 32'h0;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) misaligned_o <= 1'b0;
    else         misaligned_o <= accept && misalign && !reserved;
  end
`else
  assign misaligned_o = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (TIMEOUT_CYCLES = 8).
module tb_load_store_unit;

  logic        clk, rst_ni;
  logic        valid_i, mem_read_i, mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, result_valid_o, misaligned_o, bus_err_o;
  logic [31:0] rdata_o;
  logic        dmem_req_o, dmem_we_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  int tests = 0;
  int fails = 0;

  load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .valid_i        (valid_i),
    .mem_read_i     (mem_read_i),
    .mem_write_i    (mem_write_i),
    .funct3_i       (funct3_i),
    .addr_i         (addr_i),
    .wdata_i        (wdata_i),
    .stall_o        (stall_o),
    .result_valid_o (result_valid_o),
    .rdata_o        (rdata_o),
    .misaligned_o   (misaligned_o),
    .bus_err_o      (bus_err_o),
    .dmem_req_o     (dmem_req_o),
    .dmem_we_o      (dmem_we_o),
    .dmem_be_o      (dmem_be_o),
    .dmem_addr_o    (dmem_addr_o),
    .dmem_wdata_o   (dmem_wdata_o),
    .dmem_gnt_i     (dmem_gnt_i),
    .dmem_rvalid_i  (dmem_rvalid_i),
    .dmem_rdata_i   (dmem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=hang required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr;
    funct3_i = f3; addr_i = a; wdata_i = wd;
  endtask

  task automatic idle_inputs();
    valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    funct3_i = 3'b000; addr_i = 32'h0; wdata_i = 32'h0;
  endtask

  // One complete bus access with gnt after gnt_wait REQ cycles and immediate rvalid.
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                            input int gnt_wait, input logic [31:0] mem_data,
                            input logic [31:0] e_addr, input logic [3:0] e_be,
                            input logic [31:0] e_wd, input logic e_we,
                            input logic [31:0] e_rdata);
    drive(rd, wr, f3, a, wd);
    #1 chk({tag, ".stall_accept"}, 32'(stall_o), 32'd1);
    tick();
    idle_inputs();
    for (int i = 0; i < gnt_wait; i++) begin
      chk({tag, ".req_hold"}, 32'(dmem_req_o), 32'd1);
      chk({tag, ".addr_hold"}, dmem_addr_o, e_addr);
      chk({tag, ".be_hold"}, 32'(dmem_be_o), 32'(e_be));
      chk({tag, ".wdata_hold"}, dmem_wdata_o, e_wd);
      chk({tag, ".stall_req"}, 32'(stall_o), 32'd1);
      tick();
    end
    dmem_gnt_i = 1'b1;
    chk({tag, ".req"}, 32'(dmem_req_o), 32'd1);
    chk({tag, ".addr"}, dmem_addr_o, e_addr);
    chk({tag, ".be"}, 32'(dmem_be_o), 32'(e_be));
    chk({tag, ".wdata"}, dmem_wdata_o, e_wd);
    chk({tag, ".we"}, 32'(dmem_we_o), 32'(e_we));
    tick();
    dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = mem_data;
    chk({tag, ".req_wait"}, 32'(dmem_req_o), 32'd0);
    chk({tag, ".stall_wait"}, 32'(stall_o), 32'd1);
    chk({tag, ".rv_wait"}, 32'(result_valid_o), 32'd0);
    tick();
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i = 32'h0;
    chk({tag, ".result_valid"}, 32'(result_valid_o), 32'd1);
    chk({tag, ".rdata"}, rdata_o, e_rdata);
    chk({tag, ".stall_done"}, 32'(stall_o), 32'd0);
    chk({tag, ".bus_err"}, 32'(bus_err_o), 32'd0);
    chk({tag, ".misaligned"}, 32'(misaligned_o), 32'd0);
    tick();
    chk({tag, ".rv_clear"}, 32'(result_valid_o), 32'd0);
  endtask

  initial begin
    rst_ni = 1'b0;
    idle_inputs();
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    #12;
    chk("reset.stall", 32'(stall_o), 32'd0);
    chk("reset.req", 32'(dmem_req_o), 32'd0);
    chk("reset.rdata", rdata_o, 32'h0);
    chk("reset.be", 32'(dmem_be_o), 32'h0);
    chk("reset.rv", 32'(result_valid_o), 32'd0);
    idle_inputs();
    tick();
    rst_ni = 1'b1;
    tick();

    run_access("lw", 1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF,
               32'h100, 4'b1111, 32'h0, 0, 32'hDEADBEEF);
    run_access("lb", 1, 0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF_0000,
               32'h100, 4'b1000, 32'h0, 0, 32'hFFFFFF80);
    run_access("lbu", 1, 0, 3'b100, 32'h103, 32'h0, 0, 32'h80FF_0000,
               32'h100, 4'b1000, 32'h0, 0, 32'h00000080);
    run_access("lh", 1, 0, 3'b001, 32'h102, 32'h0, 0, 32'h80FF_0000,
               32'h100, 4'b1100, 32'h0, 0, 32'hFFFF80FF);
    run_access("lhu", 1, 0, 3'b101, 32'h100, 32'h0, 0, 32'h80FF_7F01,
               32'h100, 4'b0011, 32'h0, 0, 32'h00007F01);
    run_access("sh", 0, 1, 3'b001, 32'h202, 32'h1234ABCD, 4, 32'h55555555,
               32'h200, 4'b1100, 32'hABCDABCD, 1, 32'h00007F01);
    run_access("sb", 0, 1, 3'b000, 32'h201, 32'h000000A5, 0, 32'h55555555,
               32'h200, 4'b0010, 32'hA5A5A5A5, 1, 32'h00007F01);
    run_access("sw", 0, 1, 3'b010, 32'h300, 32'hCAFEF00D, 1, 32'h55555555,
               32'h300, 4'b1111, 32'hCAFEF00D, 1, 32'h00007F01);
    run_access("rdwr", 1, 1, 3'b010, 32'h400, 32'hFFFFFFFF, 0, 32'h11223344,
               32'h400, 4'b1111, 32'hFFFFFFFF, 0, 32'h11223344);

    // valid without read/write: no access, rdata held
    drive(1'b0, 1'b0, 3'b010, 32'h500, 32'h0);
    #1 chk("nop.stall", 32'(stall_o), 32'd0);
    tick();
    idle_inputs();
    chk("nop.req", 32'(dmem_req_o), 32'd0);
    chk("nop.rv", 32'(result_valid_o), 32'd0);
    chk("nop.rdata", rdata_o, 32'h11223344);

    // reserved funct3: straight to DONE with rdata 0; valid in DONE is ignored
    drive(1'b1, 1'b0, 3'b011, 32'h100, 32'h0);
    #1 chk("rsv.stall_accept", 32'(stall_o), 32'd1);
    tick();
    chk("rsv.rv", 32'(result_valid_o), 32'd1);
    chk("rsv.rdata", rdata_o, 32'h0);
    chk("rsv.req", 32'(dmem_req_o), 32'd0);
    drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    #1 chk("done.stall", 32'(stall_o), 32'd0);
    tick();
    idle_inputs();
    chk("done.no_restart", 32'(dmem_req_o), 32'd0);
    chk("done.rv_clear", 32'(result_valid_o), 32'd0);
    tick();

    // timeout: gnt immediately, rvalid never arrives
    drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    tick();
    idle_inputs();
    dmem_gnt_i = 1'b1;
    chk("to.req", 32'(dmem_req_o), 32'd1);
    tick();
    dmem_gnt_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("to.stall", 32'(stall_o), 32'd1);
      chk("to.rv_low", 32'(result_valid_o), 32'd0);
      tick();
    end
    chk("to.rv", 32'(result_valid_o), 32'd1);
    chk("to.bus_err", 32'(bus_err_o), 32'd1);
    chk("to.rdata", rdata_o, 32'h0);
    chk("to.stall_done", 32'(stall_o), 32'd0);
    tick();
    chk("to.bus_err_clear", 32'(bus_err_o), 32'd0);

    // misaligned word load
`ifdef LSU_MISALIGN_TRAP_EN
    drive(1'b1, 1'b0, 3'b010, 32'h102, 32'h0);
    tick();
    idle_inputs();
    chk("mis.req", 32'(dmem_req_o), 32'd0);
    chk("mis.flag", 32'(misaligned_o), 32'd1);
    chk("mis.rv", 32'(result_valid_o), 32'd1);
    chk("mis.rdata", rdata_o, 32'h0);
    tick();
    chk("mis.flag_clear", 32'(misaligned_o), 32'd0);
`else
    run_access("mis", 1, 0, 3'b010, 32'h102, 32'h0, 0, 32'h0BADF00D,
               32'h100, 4'b1111, 32'h0, 0, 32'h0BADF00D);
`endif

    // reset during WAIT abandons the access; late rvalid is ignored
    drive(1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
    tick();
    idle_inputs();
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    chk("rst.in_wait", 32'(stall_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("rst.req", 32'(dmem_req_o), 32'd0);
    chk("rst.stall", 32'(stall_o), 32'd0);
    chk("rst.rdata", rdata_o, 32'h0);
    tick();
    rst_ni = 1'b1;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = 32'h77777777;
    tick();
    dmem_rvalid_i = 1'b0;
    chk("rst.late_rv", 32'(result_valid_o), 32'd0);
    chk("rst.late_stall", 32'(stall_o), 32'd0);
    tick();
    chk("rst.late_rv2", 32'(result_valid_o), 32'd0);
    chk("rst.late_rdata", rdata_o, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
